point_test_sb_arbiter: RTL and testbench
========================================

// Module: point_test_sb_arbiter
// PURPOSE
//  Parametrised sideband-message arbiter for point-test engines (TX/RX halves and future per-lane engines).
//  Replaces fixed two-way OR/mux steering with: a 1-deep request slot per requester, round-robin grant,
//  wait-for-busy-negedge completion and a timeout. Also produces the combined test ack.
//  Sits between the point-test engines and the sideband TX interface.
// PARAMETERS
//  NUM_REQ      2    number of requesters (>=2)
//  MSG_W        4    sideband message code width
//  DATA_W       16   sideband data width
//  TIMEOUT_CYC  255  max cycles in WAIT_BUSY before abort (>=2)
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 synchronous reset, active-high
//  i_en             in   1                 block enable; low = flush
//  i_req_valid      in   NUM_REQ           1-cycle request pulse per requester
//  i_req_msg        in   NUM_REQ*MSG_W     message of req k at [k*MSG_W +: MSG_W]
//  i_req_data       in   NUM_REQ*DATA_W    data of req k at [k*DATA_W +: DATA_W]
//  i_busy           in   1                 sideband busy; its falling edge = message accepted
//  i_test_ack       in   NUM_REQ           per-engine test-finished ack
//  o_valid          out  1                 sideband message strobe (1 cycle)
//  o_sideband_message out MSG_W            granted message, held until next grant
//  o_sideband_data  out  DATA_W            granted data, held until next grant
//  o_pending        out  NUM_REQ           slot k occupied
//  o_req_done       out  NUM_REQ           1-cycle pulse: req k accepted by sideband
//  o_req_overflow   out  NUM_REQ           sticky: req k pulsed while its slot was full
//  o_timeout        out  1                 1-cycle pulse: WAIT_BUSY timed out
//  o_test_ack       out  1                 all acks high, no pending, FSM IDLE (registered)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_ptr=0; slots, timer, busy_d cleared.
//  Capture: i_req_valid[k] with slot k empty -> msg/data stored, o_pending[k]=1 next cycle.
//   Slot full -> new request dropped, o_req_overflow[k] set (sticky until rst or i_en low).
//   A capture in the same cycle as done[k] is accepted (done clears first, capture sets).
//  Busy edge: busy_d <= i_busy; negedge = busy_d & ~i_busy.
//  FSM:
//   IDLE: if any pending -> pick first pending k scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ);
//    register msg/data to outputs, gnt=k -> SEND.
//   SEND: o_valid=1 for exactly this cycle; timer cleared -> WAIT_BUSY.
//   WAIT_BUSY: on negedge -> o_req_done[gnt] pulse, clear slot gnt, rr_ptr=gnt+1 mod N -> IDLE.
//    Else timer++; timer==TIMEOUT_CYC-1 -> o_timeout pulse, slot kept (retry),
//    rr_ptr=gnt+1 mod N -> IDLE.
//  Latency: request pulse at cycle t -> o_pending at t+1 -> o_valid at t+2 (idle arbiter).
//   Min spacing between o_valid strobes = 3 cycles.
//  A busy negedge outside WAIT_BUSY is ignored.
//  o_test_ack <= (&i_test_ack) & ~(|pending) & (state==IDLE).
//  i_en low (any state, incl. mid-WAIT_BUSY): next cycle FSM=IDLE, slots/overflow/timer cleared,
//   pulses 0, rr_ptr kept. Requests are ignored while i_en is low.
//  rst mid-operation: identical to reset values next cycle, no done/timeout pulse emitted.
//  Widths: timer is $clog2(TIMEOUT_CYC+1) bits; rr_ptr is $clog2(NUM_REQ) bits, wraps N-1 -> 0.
// TESTING
//  1 NUM_REQ=2: req0 msg=4'h5 data=16'hABCD at t; busy 1 at t+3, 0 at t+6
//    -> o_valid at t+2 with 5/ABCD; o_req_done[0] at t+6; o_pending 0 at t+7.
//  2 req0 and req1 same cycle, both handshakes completed -> grant order 0 then 1.
//    Repeat with rr_ptr=1 -> order 1 then 0.
//  3 req1 pulsed twice before its grant -> o_req_overflow[1]=1; first msg sent, second dropped.
//  4 TIMEOUT_CYC=8, busy never toggles -> o_timeout 8 cycles after SEND;
//    msg re-sent (o_valid again), o_pending[k] still 1.
//  5 i_en dropped during WAIT_BUSY -> next cycle IDLE, o_pending=0, no o_req_done;
//    then i_en=1 with new req -> normal send.
//  6 i_test_ack=2'b11 while a slot is pending -> o_test_ack 0; goes 1 one cycle after idle with no pending.
//    NUM_REQ=4 random traffic -> no requester starves, every captured req gets done or overflow.

Source files
------------

// File: rtl/point_test_sb_arbiter.sv
// ============================================================================
// point_test_sb_arbiter
// ----------------------------------------------------------------------------
// Sideband-message arbiter for the point-test engines. Each requester owns a
// one-deep message slot. Occupied slots are granted round-robin. A granted
// message is strobed once on o_valid. The arbiter then waits for the falling
// edge of the sideband busy line, which means the message was accepted, or
// for a timeout. On a timeout the slot is kept, so the message is retried
// later. The block also produces the combined point-test acknowledge.
//
// Ports
//   clk                 clock
//   rst                 synchronous reset, active-high
//   i_en                block enable; low flushes slots, overflow flags, timer
//   i_req_valid[k]      one-cycle request pulse from requester k
//   i_req_msg           message of requester k at [k*MSG_W +: MSG_W]
//   i_req_data          data of requester k at [k*DATA_W +: DATA_W]
//   i_busy              sideband busy; its falling edge = message accepted
//   i_test_ack[k]       per-engine test-finished acknowledge
//   o_valid             one-cycle sideband message strobe
//   o_sideband_message  granted message, held until the next grant
//   o_sideband_data     granted data, held until the next grant
//   o_pending[k]        slot k occupied
//   o_req_done[k]       one-cycle pulse: message of requester k accepted
//   o_req_overflow[k]   sticky: requester k pulsed while its slot was full
//   o_timeout           one-cycle pulse: busy never fell within TIMEOUT_CYC
//   o_test_ack          all acks high, nothing pending, arbiter idle
// ============================================================================
module point_test_sb_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MSG_W       = 4,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*MSG_W-1:0]  i_req_msg,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic                      i_busy,
    input  logic [NUM_REQ-1:0]        i_test_ack,
    output logic                      o_valid,
    output logic [MSG_W-1:0]          o_sideband_message,
    output logic [DATA_W-1:0]         o_sideband_data,
    output logic [NUM_REQ-1:0]        o_pending,
    output logic [NUM_REQ-1:0]        o_req_done,
    output logic [NUM_REQ-1:0]        o_req_overflow,
    output logic                      o_timeout,
    output logic                      o_test_ack
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [NUM_REQ-1:0]  r_slotValid;
    logic [MSG_W-1:0]    r_slotMsg  [NUM_REQ];
    logic [DATA_W-1:0]   r_slotData [NUM_REQ];
    logic [NUM_REQ-1:0]  r_overflow;
    logic [PTR_W-1:0]    r_rrPtr;
    logic [PTR_W-1:0]    r_gnt;
    logic [TMR_W-1:0]    r_timer;
    logic                r_busyD;
    logic [MSG_W-1:0]    r_outMsg;
    logic [DATA_W-1:0]   r_outData;
    logic                r_testAck;

    logic                w_busyNegedge;
    logic                w_timerExpired;
    logic                w_grantFound;
    logic [PTR_W-1:0]    w_grantIdx;
    logic [PTR_W-1:0]    w_cand;
    logic [PTR_W-1:0]    w_gntNext;

    assign w_busyNegedge      = r_busyD & ~i_busy;
    assign w_timerExpired     = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
    assign w_gntNext          = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    assign o_pending          = r_slotValid;
    assign o_req_overflow     = r_overflow;
    assign o_sideband_message = r_outMsg;
    assign o_sideband_data    = r_outData;
    assign o_test_ack         = r_testAck;

    // Round-robin pick: the first occupied slot at or after the pointer,
    // wrapping around.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = PTR_W'((int'(r_rrPtr) + i) % NUM_REQ);
            if (!w_grantFound && r_slotValid[w_cand]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the single-cycle strobes. The strobes are forced
    // low during reset or flush, so an aborted handshake never reports a
    // completion or a timeout.
    always_comb begin
        w_nextState = r_state;
        o_valid     = 1'b0;
        o_req_done  = '0;
        o_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grantFound) begin
                    w_nextState = ST_SEND;
                end
            end
            ST_SEND: begin
                o_valid     = 1'b1;
                w_nextState = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (w_busyNegedge) begin
                    o_req_done[r_gnt] = 1'b1;
                    w_nextState       = ST_IDLE;
                end else if (w_timerExpired) begin
                    o_timeout   = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (rst || !i_en) begin
            w_nextState = ST_IDLE;
            o_valid     = 1'b0;
            o_req_done  = '0;
            o_timeout   = 1'b0;
        end
    end

    // Datapath: request slots, grant capture, timer, round-robin pointer,
    // busy edge history and the registered test acknowledge. A completion
    // and a new capture on the same slot in one cycle leave the slot full
    // with the new message.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotValid <= '0;
            r_overflow  <= '0;
            r_rrPtr     <= '0;
            r_gnt       <= '0;
            r_timer     <= '0;
            r_busyD     <= 1'b0;
            r_outMsg    <= '0;
            r_outData   <= '0;
            r_testAck   <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_slotMsg[k]  <= '0;
                r_slotData[k] <= '0;
            end
        end else begin
            r_busyD   <= i_busy;
            r_testAck <= (&i_test_ack) & ~(|r_slotValid) & (r_state == ST_IDLE);
            if (!i_en) begin
                r_slotValid <= '0;
                r_overflow  <= '0;
                r_timer     <= '0;
            end else begin
                if (r_state == ST_IDLE && w_grantFound) begin
                    r_outMsg  <= r_slotMsg[w_grantIdx];
                    r_outData <= r_slotData[w_grantIdx];
                    r_gnt     <= w_grantIdx;
                end
                if (r_state == ST_SEND) begin
                    r_timer <= '0;
                end
                if (r_state == ST_WAIT_BUSY) begin
                    if (w_busyNegedge || w_timerExpired) begin
                        r_rrPtr <= w_gntNext;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (i_req_valid[k]) begin
                        if (!r_slotValid[k] || o_req_done[k]) begin
                            r_slotValid[k] <= 1'b1;
                            r_slotMsg[k]   <= i_req_msg[k*MSG_W +: MSG_W];
                            r_slotData[k]  <= i_req_data[k*DATA_W +: DATA_W];
                        end else begin
                            r_overflow[k] <= 1'b1;
                        end
                    end else if (o_req_done[k]) begin
                        r_slotValid[k] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_point_test_sb_arbiter.sv
// ============================================================================
// tb_point_test_sb_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for point_test_sb_arbiter (NUM_REQ=2, TIMEOUT_CYC=8).
// A negedge monitor keeps a per-requester model of slot occupancy, overflow
// and expected payloads. Payloads are queued when a request is driven and
// popped when the arbiter reports completion. A cycle table covers the basic
// handshake and the test acknowledge. Hand-written sequences cover grant
// order, overflow, timeout/retry, flush, reset and random traffic.
// ============================================================================
module tb_point_test_sb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_req_valid;
    logic [7:0]  i_req_msg;
    logic [31:0] i_req_data;
    logic        i_busy;
    logic [1:0]  i_test_ack;
    logic        o_valid;
    logic [3:0]  o_sideband_message;
    logic [15:0] o_sideband_data;
    logic [1:0]  o_pending;
    logic [1:0]  o_req_done;
    logic [1:0]  o_req_overflow;
    logic        o_timeout;
    logic        o_test_ack;

    point_test_sb_arbiter #(
        .NUM_REQ(2), .MSG_W(4), .DATA_W(16), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en),
        .i_req_valid(i_req_valid), .i_req_msg(i_req_msg), .i_req_data(i_req_data),
        .i_busy(i_busy), .i_test_ack(i_test_ack),
        .o_valid(o_valid), .o_sideband_message(o_sideband_message),
        .o_sideband_data(o_sideband_data), .o_pending(o_pending),
        .o_req_done(o_req_done), .o_req_overflow(o_req_overflow),
        .o_timeout(o_timeout), .o_test_ack(o_test_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard model state, updated by the negedge monitor.
    logic        scbOn = 1'b0;
    logic [1:0]  modelFull = 2'b00;
    logic [1:0]  expOvf = 2'b00;
    logic [19:0] expQ [2][$];
    int          pushCnt = 0;
    int          doneCnt = 0;

    typedef struct {
        logic        req0;
        logic [3:0]  msg;
        logic [15:0] data;
        logic        busy;
        logic [1:0]  ack;
        logic        expValid;
        logic [1:0]  expDone;
        logic [1:0]  expPending;
        logic        expTestAck;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_req_valid = 2'b00;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [7:0] msg, input logic [31:0] data);
        tick();
        i_req_valid = req;
        i_req_msg   = msg;
        i_req_data  = data;
    endtask

    // Waits (bounded) for the next o_valid; n = cycles waited, -1 on expiry.
    task automatic waitValid(output int n, output logic [3:0] msg);
        n   = -1;
        msg = 4'h0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            @(negedge clk);
            if (o_valid) begin
                n   = c;
                msg = o_sideband_message;
                break;
            end
        end
        if (n < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL valid_wait: got none expected o_valid within 20 cycles");
        end
    endtask

    // Completes a busy handshake starting from the SEND cycle.
    task automatic handshake();
        tick();
        i_busy = 1'b1;
        tick();
        tick();
        i_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic serveOne(output logic [3:0] msg);
        int n;
        waitValid(n, msg);
        if (n > 0) handshake();
    endtask

    task automatic doReset();
        tick();
        rst    = 1'b1;
        i_busy = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("rst_valid", 32'(o_valid), 32'h0);
        checkOutput("rst_msg", 32'(o_sideband_message), 32'h0);
        checkOutput("rst_data", 32'(o_sideband_data), 32'h0);
        checkOutput("rst_pending", 32'(o_pending), 32'h0);
        checkOutput("rst_done", 32'(o_req_done), 32'h0);
        checkOutput("rst_ovf", 32'(o_req_overflow), 32'h0);
        checkOutput("rst_timeout", 32'(o_timeout), 32'h0);
        checkOutput("rst_testack", 32'(o_test_ack), 32'h0);
        tick();
        rst = 1'b0;
    endtask

    // Negedge monitor: checks occupancy, pops payloads on completion, then
    // captures new requests (completion frees the slot first).
    always @(negedge clk) begin
        if (scbOn) begin
            checkOutput("pending", 32'(o_pending), 32'(modelFull));
            if (rst || !i_en) begin
                modelFull = 2'b00;
                expOvf    = 2'b00;
                for (int k = 0; k < 2; k++) expQ[k].delete();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (o_req_done[k]) begin
                        doneCnt++;
                        if (expQ[k].size() == 0) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL done_unexpected: got done[%0d] expected none", k);
                        end else begin
                            checkOutput("done_payload", 32'({o_sideband_message, o_sideband_data}),
                                        32'(expQ[k].pop_front()));
                        end
                        modelFull[k] = 1'b0;
                    end
                    if (i_req_valid[k]) begin
                        if (!modelFull[k]) begin
                            expQ[k].push_back({i_req_msg[k*4 +: 4], i_req_data[k*16 +: 16]});
                            modelFull[k] = 1'b1;
                            pushCnt++;
                        end else begin
                            expOvf[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int          n;
        logic [3:0]  m1;
        logic [3:0]  m2;
        logic        sawValid;
        logic        respond;
        logic        active;
        int          waitC;
        int          holdC;

        rst = 1'b1; i_en = 1'b1; i_req_valid = 2'b00; i_req_msg = 8'h0;
        i_req_data = 32'h0; i_busy = 1'b0; i_test_ack = 2'b11;

        // Basic handshake: request at row 0, strobe at row 2, busy high
        // rows 3-5, done at row 6, slot empty at row 7, ack one cycle later.
        //          req  msg   data      busy  ack    val  done   pend   tack
        vecs[0]  = '{1'b1, 4'h5, 16'hABCD, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[1]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1};
        vecs[2]  = '{1'b0, 4'h5, 16'hABCD, 1'b0, 2'b11, 1'b1, 2'b00, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b01, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 16'h0000, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1};

        doReset();
        scbOn = 1'b1;
        tick();
        tick();

        for (int r = 0; r < 12; r++) begin
            applyStimulus({1'b0, vecs[r].req0}, {4'h0, vecs[r].msg}, {16'h0, vecs[r].data});
            i_busy     = vecs[r].busy;
            i_test_ack = vecs[r].ack;
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_valid", r), 32'(o_valid), 32'(vecs[r].expValid));
            checkOutput($sformatf("tbl%0d_done", r), 32'(o_req_done), 32'(vecs[r].expDone));
            checkOutput($sformatf("tbl%0d_pend", r), 32'(o_pending), 32'(vecs[r].expPending));
            checkOutput($sformatf("tbl%0d_tack", r), 32'(o_test_ack), 32'(vecs[r].expTestAck));
            checkOutput($sformatf("tbl%0d_tmo", r), 32'(o_timeout), 32'h0);
            if (vecs[r].expValid) begin
                checkOutput($sformatf("tbl%0d_msg", r), 32'(o_sideband_message), 32'(vecs[r].msg));
                checkOutput($sformatf("tbl%0d_data", r), 32'(o_sideband_data), 32'(vecs[r].data));
            end
        end

        // Grant order from a fresh pointer: 0 then 1.
        doReset();
        applyStimulus(2'b11, {4'h2, 4'h1}, {16'h2222, 16'h1111});
        @(negedge clk);
        serveOne(m1);
        serveOne(m2);
        checkOutput("rr_order_ptr0", 32'({m1, m2}), 32'h12);

        // After a lone grant to 0 the pointer is 1: order 1 then 0.
        doReset();
        applyStimulus(2'b01, 8'h03, 32'h0000_3333);
        @(negedge clk);
        serveOne(m1);
        applyStimulus(2'b11, {4'h2, 4'h1}, {16'h2222, 16'h1111});
        @(negedge clk);
        serveOne(m1);
        serveOne(m2);
        checkOutput("rr_order_ptr1", 32'({m1, m2}), 32'h21);

        // Overflow: second pulse on requester 1 before its grant is dropped.
        applyStimulus(2'b10, 8'h70, 32'h7777_0000);
        @(negedge clk);
        applyStimulus(2'b10, 8'h80, 32'h8888_0000);
        @(negedge clk);
        serveOne(m1);
        checkOutput("ovf_first_sent", 32'(m1), 32'h7);
        checkOutput("ovf_flag", 32'(o_req_overflow), 32'h2);
        sawValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            if (o_valid) sawValid = 1'b1;
        end
        checkOutput("ovf_second_dropped", 32'(sawValid), 32'h0);

        // Timeout: busy never moves; abort 8 cycles after SEND, then retry.
        applyStimulus(2'b01, 8'h09, 32'h0000_1234);
        @(negedge clk);
        waitValid(n, m1);
        checkOutput("latency", 32'(n), 32'd2);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            @(negedge clk);
            if (o_timeout) begin
                n = c;
                break;
            end
        end
        checkOutput("timeout_cycles", 32'(n), 32'd8);
        checkOutput("timeout_pend", 32'(o_pending[0]), 32'h1);
        checkOutput("timeout_no_done", 32'(o_req_done), 32'h0);
        waitValid(n, m1);
        checkOutput("retry_gap", 32'(n), 32'd2);
        checkOutput("retry_msg", 32'(m1), 32'h9);
        if (n > 0) handshake();

        // Flush mid-WAIT_BUSY: no completion, slots and overflow cleared.
        applyStimulus(2'b01, 8'h0A, 32'h0000_AAAA);
        @(negedge clk);
        waitValid(n, m1);
        tick();
        i_busy = 1'b1;
        @(negedge clk);
        tick();
        i_busy = 1'b0;
        i_en   = 1'b0;
        @(negedge clk);
        checkOutput("flush_no_done", 32'(o_req_done), 32'h0);
        tick();
        i_en = 1'b1;
        @(negedge clk);
        checkOutput("flush_pend", 32'(o_pending), 32'h0);
        checkOutput("flush_ovf", 32'(o_req_overflow), 32'h0);
        checkOutput("flush_valid", 32'(o_valid), 32'h0);
        checkOutput("flush_done", 32'(o_req_done), 32'h0);
        applyStimulus(2'b10, 8'hC0, 32'hCCCC_0000);
        @(negedge clk);
        serveOne(m1);
        checkOutput("after_flush_msg", 32'(m1), 32'hC);

        // Reset in the middle of a handshake: nothing reported, all cleared.
        applyStimulus(2'b01, 8'h03, 32'h0000_0303);
        @(negedge clk);
        waitValid(n, m1);
        tick();
        i_busy = 1'b1;
        @(negedge clk);
        tick();
        i_busy = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_done", 32'(o_req_done), 32'h0);
        checkOutput("rst_mid_tmo", 32'(o_timeout), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_pend", 32'(o_pending), 32'h0);
        checkOutput("rst_mid_msg", 32'({o_sideband_message, o_sideband_data}), 32'h0);

        // Random traffic with a responder that sometimes ignores a strobe.
        pushCnt = 0;
        doneCnt = 0;
        active  = 1'b0;
        waitC   = 0;
        holdC   = 0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (c < 600) begin
                i_req_valid[0] = ($urandom_range(0, 3) == 0);
                i_req_valid[1] = ($urandom_range(0, 3) == 0);
                i_req_msg      = 8'($urandom);
                i_req_data     = $urandom;
            end
            if (o_valid) begin
                respond = (c >= 600) || ($urandom_range(0, 7) != 0);
                active  = respond;
                waitC   = $urandom_range(0, 2);
                holdC   = $urandom_range(1, 3);
                i_busy  = 1'b0;
            end else if (active) begin
                if (waitC > 0) begin
                    waitC--;
                end else if (holdC > 0) begin
                    i_busy = 1'b1;
                    holdC--;
                end else begin
                    i_busy = 1'b0;
                    active = 1'b0;
                end
            end
            @(negedge clk);
        end
        checkOutput("rand_q0_drained", 32'(expQ[0].size()), 32'h0);
        checkOutput("rand_q1_drained", 32'(expQ[1].size()), 32'h0);
        checkOutput("rand_all_done", 32'(doneCnt), 32'(pushCnt));
        checkOutput("rand_pend_empty", 32'(o_pending), 32'h0);
        checkOutput("rand_ovf", 32'(o_req_overflow), 32'(expOvf));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
